// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pipe_pkg
// Description : Shared pipeline exception codes and stage payload type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int C_PIPE_INSTR_W = 32;
    localparam int C_PIPE_ADDR_W  = 32;

    typedef struct packed {
        logic [C_PIPE_INSTR_W-1:0] instr;
        logic [C_PIPE_ADDR_W-1:0]  pc4;
        logic                      isj;
        logic [4:0]                exc;
    } stage_payload_t;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/ifid_pc_check.sv
`default_nettype none
// ============================================================================
// Module      : ifid_pc_check
// Description : Combinational fetch-address legality check (pc4 -> exc code).
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_pc_check
    import mips_pipe_pkg::*;
#(
    parameter int              ADDR_W = 32,
    parameter logic [ADDR_W-1:0] PC4_LO = 32'h0000_3004,
    parameter logic [ADDR_W-1:0] PC4_HI = 32'h0000_5000
) (
    input  logic [ADDR_W-1:0] pc4,
    output logic [4:0]        exc
);

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned   = (pc4[1:0] != 2'b00);
    // Both bounds are inclusive.
    assign w_out_of_range = (pc4 < PC4_LO) || (pc4 > PC4_HI);
    assign exc            = (w_misaligned || w_out_of_range) ? EXC_ADEL : EXC_NONE;

endmodule : ifid_pc_check
`default_nettype wire

// File: rtl/fetch_decode_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_pipe_reg
// Description : IF->ID pipeline register with valid/ready handshake and AdEL
//               tagging. Define IFID_SKID_EN for a 2-entry registered-ready
//               skid buffer; otherwise a single entry with combinational ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int                INSTR_W = 32,
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] PC4_LO  = 32'h0000_3004,
    parameter logic [ADDR_W-1:0] PC4_HI  = 32'h0000_5000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc4,
    input  logic               in_isj,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc4,
    output logic               out_isj,
    output logic [4:0]         out_exc
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc4;
        logic               isj;
        logic [4:0]         exc;
    } payload_t;

    logic [4:0] w_exc;
    payload_t   w_cap;
    payload_t   r_main;
    logic       r_valid;
    logic       w_in_xfer;

    ifid_pc_check #(
        .ADDR_W (ADDR_W),
        .PC4_LO (PC4_LO),
        .PC4_HI (PC4_HI)
    ) u_pc_check (
        .pc4 (in_pc4),
        .exc (w_exc)
    );

    // A faulting fetch never exposes its instruction word downstream.
    assign w_cap.instr = (w_exc == EXC_NONE) ? in_instr : '0;
    assign w_cap.pc4   = in_pc4;
    assign w_cap.isj   = in_isj;
    assign w_cap.exc   = w_exc;

    assign w_in_xfer = in_valid && in_ready;

`ifdef IFID_SKID_EN
    payload_t r_skid;
    logic     r_skid_valid;

    assign in_ready = !r_skid_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main       <= '0;
            r_valid      <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main       <= '0;
            r_valid      <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (!r_valid || out_ready) begin
            // Main is free this edge; the skid entry is older so it goes first.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_valid      <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_main  <= w_cap;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid       <= w_cap;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = out_ready || !r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main  <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_main  <= '0;
            r_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_main  <= w_cap;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

    assign out_valid = r_valid;
    assign out_instr = r_main.instr;
    assign out_pc4   = r_main.pc4;
    assign out_isj   = r_main.isj;
    assign out_exc   = r_main.exc;

endmodule : fetch_decode_pipe_reg
`default_nettype wire
